// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the PE control block.
package pe_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ACC   = 3'd2,
        S_STORE = 3'd3,
        S_WRITE = 3'd4,
        S_FILE  = 3'd5,
        S_DONE  = 3'd6
    } pe_state_t;

    localparam int unsigned WIN_SIZE       = 4;
    localparam int unsigned WIN_TAPS       = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = 8;

    // Number of window positions along one image edge.
    function automatic int unsigned out_dim(input int unsigned img_size, input int unsigned stride);
        return (img_size - WIN_SIZE) / stride + 1;
    endfunction

    function automatic int unsigned num_words(input int unsigned img_size, input int unsigned stride);
        int unsigned wins;
        wins = out_dim(img_size, stride) * out_dim(img_size, stride);
        return (wins + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/pe_win_cntr.sv
// Row/column stride counter for the 4x4 window; produces the top-left pixel index.
module pe_win_cntr
    import pe_pkg::*;
#(
    parameter int unsigned IMG_SIZE = 16,
    parameter int unsigned STRIDE   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [IDX_W-1:0] img_buffer_index,
    output logic             last_win,
    output logic             pass_done
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(IMG_SIZE - WIN_SIZE);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(STRIDE);
    localparam logic [IDX_W-1:0] IMG_W    = IDX_W'(IMG_SIZE);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             done_q, done_d;

    assign last_win         = (row_q == LAST_POS) && (col_q == LAST_POS);
    assign img_buffer_index = index_q;
    assign pass_done        = done_q;

    // The last window parks the counter and raises pass_done instead of wrapping.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        done_d = done_q;
        if (clr) begin
            row_d  = '0;
            col_d  = '0;
            done_d = 1'b0;
        end else if (adv) begin
            if (last_win) begin
                done_d = 1'b1;
            end else if (col_q == LAST_POS) begin
                col_d = '0;
                row_d = row_q + STEP;
            end else begin
                col_d = col_q + STEP;
            end
        end
        index_d = row_d * IMG_W + col_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q   <= '0;
            col_q   <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/pe_ctrl.sv
// Control FSM for one PE datapath: window walk, accumulate, byte packing, word writes, file dump.
// Optional stall input enabled by defining PE_CTRL_HOLD_EN.
module pe_ctrl
    import pe_pkg::*;
#(
    parameter int unsigned IMG_SIZE     = 16,
    parameter int unsigned STRIDE       = 4,
    parameter int unsigned MAX_MEM_SIZE = 128
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PE_CTRL_HOLD_EN
    input  logic             hold,
`endif
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rst_acc,
    output logic             acc_en,
    output logic [IDX_W-1:0] buffer_cntr,
    output logic [IDX_W-1:0] img_buffer_index,
    output logic             res_buffer_en,
    output logic [IDX_W-1:0] res_index,
    output logic             rst_res_reg,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_adr,
    output logic             wr_file
);

    localparam int unsigned NUM_WORDS = num_words(IMG_SIZE, STRIDE);
    localparam logic [IDX_W-1:0] LAST_TAP  = IDX_W'(WIN_TAPS - 1);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BYTES_PER_WORD - 1);

    if ((IMG_SIZE - WIN_SIZE) % STRIDE != 0) begin : g_bad_stride
        $error("pe_ctrl: window does not tile the image with this STRIDE");
    end
    if (IMG_SIZE * IMG_SIZE > 256) begin : g_bad_img
        $error("pe_ctrl: image too large for an 8-bit pixel index");
    end
    if (NUM_WORDS > MAX_MEM_SIZE) begin : g_bad_mem
        $error("pe_ctrl: result words exceed MAX_MEM_SIZE");
    end

    pe_state_t        state_q, state_d;
    logic [IDX_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic [IDX_W-1:0] wr_adr_q, wr_adr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rst_acc_q, rst_acc_d;
    logic             acc_en_q, acc_en_d;
    logic             res_buffer_en_q, res_buffer_en_d;
    logic             rst_res_reg_q, rst_res_reg_d;
    logic             wr_en_q, wr_en_d;
    logic             wr_file_q, wr_file_d;
    logic             hold_c;
    logic             win_clr_c, win_adv_c;
    logic             last_win_c, pass_done_c;

`ifdef PE_CTRL_HOLD_EN
    assign hold_c = hold;
`else
    assign hold_c = 1'b0;
`endif

    pe_win_cntr #(
        .IMG_SIZE (IMG_SIZE),
        .STRIDE   (STRIDE)
    ) u_win (
        .clk              (clk),
        .rst              (rst),
        .clr              (win_clr_c),
        .adv              (win_adv_c),
        .img_buffer_index (img_buffer_index),
        .last_win         (last_win_c),
        .pass_done        (pass_done_c)
    );

    // Next state and counters; hold freezes everything at its current value.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        res_idx_d = res_idx_q;
        wr_adr_d  = wr_adr_q;
        win_clr_c = 1'b0;
        win_adv_c = 1'b0;
        if (!hold_c) begin
            unique case (state_q)
                S_IDLE: begin
                    win_clr_c = 1'b1;
                    res_idx_d = '0;
                    wr_adr_d  = '0;
                    if (start) state_d = S_CLR;
                end
                S_CLR:   state_d = S_ACC;
                S_ACC: begin
                    if (buf_q == LAST_TAP) state_d = S_STORE;
                end
                S_STORE: begin
                    win_adv_c = 1'b1;
                    res_idx_d = (res_idx_q == LAST_LANE) ? '0 : res_idx_q + 1'b1;
                    state_d   = (res_idx_q == LAST_LANE || last_win_c) ? S_WRITE : S_CLR;
                end
                S_WRITE: begin
                    wr_adr_d  = wr_adr_q + 1'b1;
                    res_idx_d = '0;
                    state_d   = pass_done_c ? S_FILE : S_CLR;
                end
                S_FILE:  state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            buf_d = (state_q == S_ACC && state_d == S_ACC) ? buf_q + 1'b1 : '0;
        end
    end

    // Outputs are decoded from the next state so the registers line up with state_q.
    always_comb begin
        busy_d          = !(state_d inside {S_IDLE, S_DONE});
        done_d          = (state_d == S_DONE);
        rst_acc_d       = (state_d == S_CLR);
        acc_en_d        = (state_d == S_ACC);
        res_buffer_en_d = (state_d == S_STORE);
        rst_res_reg_d   = (state_d == S_CLR) && (res_idx_d == '0);
        wr_en_d         = (state_d == S_WRITE);
        wr_file_d       = (state_d == S_FILE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            buf_q           <= '0;
            res_idx_q       <= '0;
            wr_adr_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            rst_acc_q       <= 1'b0;
            acc_en_q        <= 1'b0;
            res_buffer_en_q <= 1'b0;
            rst_res_reg_q   <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_file_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_q           <= buf_d;
            res_idx_q       <= res_idx_d;
            wr_adr_q        <= wr_adr_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            rst_acc_q       <= rst_acc_d;
            acc_en_q        <= acc_en_d;
            res_buffer_en_q <= res_buffer_en_d;
            rst_res_reg_q   <= rst_res_reg_d;
            wr_en_q         <= wr_en_d;
            wr_file_q       <= wr_file_d;
        end
    end

    // Strobes are masked while stalled so no tap or write is issued twice.
    assign busy          = busy_q;
    assign done          = done_q & ~hold_c;
    assign rst_acc       = rst_acc_q & ~hold_c;
    assign acc_en        = acc_en_q & ~hold_c;
    assign res_buffer_en = res_buffer_en_q & ~hold_c;
    assign rst_res_reg   = rst_res_reg_q & ~hold_c;
    assign wr_en         = wr_en_q & ~hold_c;
    assign wr_file       = wr_file_q & ~hold_c;
    assign buffer_cntr   = buf_q;
    assign res_index     = res_idx_q;
    assign wr_adr        = wr_adr_q;

endmodule

// File: doc/pe_ctrl.md
Name: pe_ctrl

Overview:
Control FSM for one PE datapath. It walks a 4x4 window over an IMG_SIZE x IMG_SIZE image with stride STRIDE, and sequences the MAC accumulate, result-byte packing and memory write strobes. At the end it triggers the result-file dump. It sits directly upstream of the PE datapath and drives all of that stage's control/index inputs from a single start/done handshake.

Parameters:
- IMG_SIZE, 16, image edge length in pixels.
- STRIDE, 4, window step in pixels, applied to both row and column.
- MAX_MEM_SIZE, 128, depth of the datapath result memory, in 32-bit words.

Ports:
- clk, input, 1, clock; all state changes on rising edge.
- rst, input, 1, reset; asynchronous, active-low.
- start, input, 1, begin one layer pass; sampled only in IDLE.
- busy, output, 1, high from the first cycle after start is accepted until DONE.
- done, output, 1, one-cycle pulse when the pass completes.
- rst_acc, output, 1, clears the MAC accumulators.
- acc_en, output, 1, MAC accumulate enable.
- buffer_cntr, output, 8, tap index 0..15 within the 4x4 window.
- img_buffer_index, output, 8, linear index of the window top-left pixel.
- res_buffer_en, output, 1, writes one result byte into the 4-byte result register.
- res_index, output, 8, byte lane 0..3 for res_buffer_en.
- rst_res_reg, output, 1, clears the 4-byte result register.
- wr_en, output, 1, writes the packed word to memory.
- wr_adr, output, 8, memory word address.
- wr_file, output, 1, one-cycle pulse requesting the memory file dump.

Behaviour:
- Derived quantities:
  - OUT_DIM = (IMG_SIZE-4)/STRIDE+1.
  - NUM_WIN = OUT_DIM^2.
  - NUM_WORDS = ceil(NUM_WIN/4).
- Elaboration error if any of the following holds:
  - (IMG_SIZE-4) % STRIDE != 0
  - IMG_SIZE*IMG_SIZE > 256
  - NUM_WORDS > MAX_MEM_SIZE
- Reset (rst low, asynchronous): state=IDLE; every output 0; all counters 0.
- States: IDLE, CLR, ACC, STORE, WRITE, FILE, DONE.
- IDLE:
  - start=1 -> CLR.
  - Window row/column, res_index and wr_adr are zeroed.
- CLR (1 cycle):
  - rst_acc=1.
  - rst_res_reg=1 when res_index==0.
  - buffer_cntr=0.
  - -> ACC.
- ACC (16 cycles):
  - acc_en=1; buffer_cntr counts 0..15.
  - After the cycle with buffer_cntr==15 -> STORE.
- STORE (1 cycle):
  - res_buffer_en=1 with the current res_index.
  - Then advance the window: column += STRIDE; on column overflow, column=0 and row += STRIDE.
  - res_index increments mod 4.
  - -> WRITE if res_index was 3 or this was the last window; else -> CLR.
- WRITE (1 cycle):
  - wr_en=1 at the current wr_adr; wr_adr then increments.
  - -> FILE if the last window is done, else -> CLR.
  - res_index is forced to 0 on exit, so a partial last word keeps its unwritten high lanes at 0 (cleared at that word's first CLR).
- FILE (1 cycle): wr_file=1 -> DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Window index: img_buffer_index = row*IMG_SIZE + column, held constant throughout CLR/ACC/STORE of that window.
- busy is high in all states except IDLE and DONE.
- start while busy is ignored; start held high across DONE re-launches from IDLE on the next edge.
- Latency: 18 cycles per window, plus 1 per word, plus FILE and DONE.
- Reset mid-pass aborts immediately; no wr_en or wr_file is issued afterwards.

Optional Feature:
PE_CTRL_HOLD_EN:
- When defined, adds input hold (1 bit). While hold=1:
  - the FSM and all counters freeze;
  - rst_acc, acc_en, res_buffer_en, rst_res_reg, wr_en, wr_file and done are forced to 0;
  - index outputs keep their values.
- Resuming continues exactly where it stopped, with no lost or repeated tap.
- hold in IDLE blocks start acceptance.
- Without the macro, the port is absent and the FSM never stalls.

Decomposition:
- Package pe_pkg:
  - state enum pe_state_t;
  - WIN_SIZE=4, WIN_TAPS=16, BYTES_PER_WORD=4;
  - function out_dim(IMG_SIZE, STRIDE).
- One natural sub-module, pe_win_cntr: row/column stride counter producing img_buffer_index and last_win.

Test Plan:
- Default params; start pulse:
  - img_buffer_index sequence 0,4,8,12,64,68,...,204;
  - 16 acc_en bursts of 16 cycles;
  - wr_en 4 times at wr_adr 0..3;
  - one wr_file;
  - done 294 cycles after start is sampled.
- IMG_SIZE=8, STRIDE=2:
  - indices 0,2,4,16,18,20,32,34,36;
  - wr_adr 0,1,2;
  - third WRITE follows after only 1 STORE;
  - rst_res_reg fires at windows 0, 4 and 8.
- Start asserted while busy, then start held through DONE:
  - first pass is unaffected;
  - second pass begins one cycle after done.
- rst low in the middle of ACC of window 5:
  - all outputs 0 asynchronously; state IDLE;
  - no further wr_en or wr_file;
  - a fresh start restarts at index 0.
- PE_CTRL_HOLD_EN, hold=1 for 7 cycles at buffer_cntr==9:
  - acc_en=0 and buffer_cntr stays 9;
  - total acc_en count per window remains 16;
  - done is delayed by exactly 7 cycles.
